arbitro_rr16: RTL and testbench

Round-robin arbiter that shares one resource among 16 requesters and drives the grant as both a 4-bit index and its one-hot 16-bit decode. It sits in front of the shared resource whose select lines are one-hot decoded from a 4-bit code. The block sequences ownership: grant, hold, release or timeout, then rotate priority.

---
 rtl/arbitro_rr16.sv | 132 +++++++++++++
 tb/tb_arbitro_rr16.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr16.sv
// arbitro_rr16 -- round-robin arbiter for 16 requesters sharing one resource.
//
// A grant is held until the holder pulses rel, drops its request, or
// (with MAX_HOLD != 0) reaches MAX_HOLD cycles while another requester is
// pending. After every grant the arbiter spends at least one cycle idle and
// the priority pointer moves to the requester just after the last holder.
//
// Parameters:
//   MAX_HOLD   maximum grant length under contention (0 = no timeout, 0..255)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        level-sensitive request vector, bit i = requester i
//   rel        single-cycle release pulse from the current holder
//              (the holder's "release" strobe; that word is reserved in SV)
//   gnt        registered one-hot grant, zero when no grant is active
//   gnt_idx    registered index of the granted requester, holds when idle
//   gnt_valid  a grant is active
//   forced     one-cycle pulse in the idle cycle following a timed-out grant
module arbitro_rr16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        rel,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        forced
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [15:0] gnt_nxt;
    logic [3:0]  idx_nxt;
    logic        valid_nxt;
    logic        forced_nxt;

    logic [3:0]  sel_idx;
    logic        sel_found;
    logic [3:0]  cand;
    logic [15:0] others;
    logic        timeout;
    logic        end_grant;

    // First set request bit scanning upward from ptr, wrapping at 16.
    always_comb begin
        sel_idx   = ptr;
        sel_found = 1'b0;
        cand      = ptr;
        for (int unsigned i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!sel_found && req[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    // gnt is one-hot of gnt_idx while granting, so it masks out the holder.
    assign others    = req & ~gnt;
    assign timeout   = TIMEOUT_EN && (hold_cnt == HOLD_LAST) && (others != '0);
    assign end_grant = rel || !req[gnt_idx] || timeout;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        hold_nxt   = hold_cnt;
        gnt_nxt    = gnt;
        idx_nxt    = gnt_idx;
        valid_nxt  = gnt_valid;
        forced_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = GRANT;
                    idx_nxt   = sel_idx;
                    gnt_nxt   = 16'h0001 << sel_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    valid_nxt  = 1'b0;
                    ptr_nxt    = gnt_idx + 4'd1;
                    // A normal end (release or withdrawal) takes precedence.
                    forced_nxt = !rel && req[gnt_idx];
                end else if (hold_cnt != 8'hFF) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            forced    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            forced    <= forced_nxt;
        end
    end

endmodule

// File: tb/tb_arbitro_rr16.sv
// tb_arbitro_rr16 -- directed bench for arbitro_rr16 (MAX_HOLD = 8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_arbitro_rr16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        forced;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    arbitro_rr16 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .forced    (forced)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] idx);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
        check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, ".gnt"}, 32'(gnt), 32'(16'h0001 << idx));
        check({tag, ".forced"}, 32'(forced), 32'd0);
    endtask

    task automatic check_idle(input string tag, input logic exp_forced);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
        check({tag, ".gnt"}, 32'(gnt), 32'd0);
        check({tag, ".forced"}, 32'(forced), 32'(exp_forced));
    endtask

    initial begin
        logic [3:0] rr_seq [4];
        rr_seq = '{4'd0, 4'd15, 4'd0, 4'd15};

        rst = 1'b1;
        req = '0;
        rel = 1'b0;

        // Reset values
        tick();
        tick();
        check_idle("reset", 1'b0);
        check("reset.idx", 32'(gnt_idx), 32'd0);

        // Basic grant: valid one cycle after req, held until release
        rst = 1'b0;
        req = 16'h0001;
        tick();
        check_grant("basic.g1", 4'd0);
        tick();
        check_grant("basic.g2", 4'd0);
        tick();
        check_grant("basic.g3", 4'd0);
        rel = 1'b1;                 // release and withdrawal together: one normal end
        req = '0;
        tick();
        check_idle("basic.end", 1'b0);
        check("basic.idx_hold", 32'(gnt_idx), 32'd0);
        rel = 1'b0;
        tick();
        check_idle("basic.idle", 1'b0);

        // Release while idle is ignored
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        check_idle("idle_rel", 1'b0);

        // Round-robin with ptr back at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_grant($sformatf("rr%0d.c1", k), rr_seq[k]);
            tick();
            check_grant($sformatf("rr%0d.c2", k), rr_seq[k]);
            tick();
            check_grant($sformatf("rr%0d.c3", k), rr_seq[k]);
            rel = 1'b1;
            tick();
            rel = 1'b0;
            check_idle($sformatf("rr%0d.gap", k), 1'b0);
        end
        req = '0;
        tick();
        check_idle("rr.quiet", 1'b0);

        // Wrap-around: after releasing idx 14, ptr=15, so 0 wins over 14
        req = 16'h4000;
        tick();
        check_grant("wrap.g14", 4'd14);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        check_idle("wrap.end", 1'b0);
        req = 16'h4001;
        tick();
        check_grant("wrap.g0", 4'd0);
        req = '0;                   // holder withdraws
        tick();
        check_idle("wrap.withdraw", 1'b0);

        // Timeout: 8 cycles each, forced pulse in the gap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 16'h0003;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check_grant($sformatf("to0.c%0d", c), 4'd0);
            tick();
        end
        check_idle("to0.forced", 1'b1);
        tick();
        for (int c = 1; c <= 8; c++) begin
            check_grant($sformatf("to1.c%0d", c), 4'd1);
            tick();
        end
        check_idle("to1.forced", 1'b1);
        req = '0;
        tick();
        check_idle("to.after", 1'b0);

        // No contention: never forced (ptr=2, so idx 4 granted)
        req = 16'h0010;
        tick();
        check_grant("solo.c1", 4'd4);
        for (int c = 2; c <= 20; c++) begin
            tick();
            check_grant($sformatf("solo.c%0d", c), 4'd4);
        end
        req = '0;
        tick();
        check_idle("solo.end", 1'b0);

        // Reset mid-grant (ptr=5 here, so idx 5 granted first)
        req = 16'h00A0;
        tick();
        check_grant("rstmid.pre", 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rstmid.rst", 1'b0);
        check("rstmid.idx", 32'(gnt_idx), 32'd0);
        tick();
        check_grant("rstmid.post", 4'd5);
        req = '0;
        tick();
        check_idle("rstmid.end", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
